accum_stream: RTL and testbench

Parametrised streaming block accumulator, the next generation of the fixed 8-sample loop-unrolling `dut`. It consumes `N_SAMPLES` unsigned `DIN_W`-bit samples over a busy/valid point-to-point input channel. It emits one full-precision sum per block over a busy/valid output channel. It sits behind the cosim wrapper as the DUT of the `lab_loop_unrolling` family; the default parameters reproduce the 8-bit-in / 11-bit-out interface.

---
 rtl/accum_stream.sv | 136 +++++++++++++
 tb/tb_accum_stream.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/accum_stream.sv
// Streaming block accumulator: sums N_SAMPLES unsigned samples per block over busy/valid channels.
// Optional averaging output is enabled by defining ACCUM_STREAM_AVG_EN.
module accum_stream #(
  parameter int DIN_W     = 8,
  parameter int N_SAMPLES = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic                                 din_busy,
  input  logic                                 din_vld,
  input  logic [DIN_W-1:0]                     din_data,
  input  logic                                 dout_busy,
  output logic                                 dout_vld,
  output logic [DIN_W+$clog2(N_SAMPLES)-1:0]   dout_data
`ifdef ACCUM_STREAM_AVG_EN
  ,
  input  logic                                 avg_mode
`endif
);

  localparam int CNT_W = $clog2(N_SAMPLES);
  localparam int OUT_W = DIN_W + CNT_W;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               din_busy_q, din_busy_d;
  logic               dout_vld_q, dout_vld_d;
  logic [OUT_W-1:0]   dout_data_q, dout_data_d;
  logic               in_xfer;
  logic               last_smp;
  logic               avg_sel;

  // Averaging truncates: the divide by a power of two is a plain right shift.
  function automatic logic [OUT_W-1:0] calc_result(input logic [OUT_W-1:0] sum,
                                                   input logic             avg);
    if (avg) begin
      calc_result = sum >> CNT_W;
    end else begin
      calc_result = sum;
    end
  endfunction

  assign in_xfer  = (state_q == ST_ACC) && din_vld && !din_busy_q;
  assign last_smp = (cnt_q == CNT_W'(N_SAMPLES - 1));

`ifdef ACCUM_STREAM_AVG_EN
  logic avg_q, avg_d;

  // Mode is captured on the first sample of a block and held until the block closes.
  always_comb begin
    avg_d = avg_q;
    if (in_xfer && (cnt_q == '0)) begin
      avg_d = avg_mode;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      avg_q <= 1'b0;
    end else begin
      avg_q <= avg_d;
    end
  end

  assign avg_sel = avg_q;
`else
  assign avg_sel = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    din_busy_d  = din_busy_q;
    dout_vld_d  = dout_vld_q;
    dout_data_d = dout_data_q;
    case (state_q)
      ST_ACC: begin
        din_busy_d = 1'b0;
        if (in_xfer) begin
          if (last_smp) begin
            dout_data_d = calc_result(acc_q + OUT_W'(din_data), avg_sel);
            dout_vld_d  = 1'b1;
            din_busy_d  = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = ST_OUT;
          end else begin
            acc_d = acc_q + OUT_W'(din_data);
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OUT: begin
        if (!dout_busy) begin
          dout_vld_d = 1'b0;
          din_busy_d = 1'b0;
          state_d    = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // din_busy resets high so nothing is accepted until the first edge out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      din_busy_q  <= 1'b1;
      dout_vld_q  <= 1'b0;
      dout_data_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      din_busy_q  <= din_busy_d;
      dout_vld_q  <= dout_vld_d;
      dout_data_q <= dout_data_d;
    end
  end

  assign din_busy  = din_busy_q;
  assign dout_vld  = dout_vld_q;
  assign dout_data = dout_data_q;

endmodule

// File: tb/tb_accum_stream.sv
// Directed self-checking bench for accum_stream: default 8x8 instance plus a 16-bit, 4-sample instance.
// Averaging steps are built only when ACCUM_STREAM_AVG_EN is defined.
module tb_accum_stream;

  logic        clk;
  logic        rst;
  logic        din_busy, din_vld, dout_busy, dout_vld;
  logic [7:0]  din_data;
  logic [10:0] dout_data;
  logic        b_din_busy, b_din_vld, b_dout_busy, b_dout_vld;
  logic [15:0] b_din_data;
  logic [17:0] b_dout_data;
`ifdef ACCUM_STREAM_AVG_EN
  logic        avg_mode;
`endif

  int checks;
  int failures;

  accum_stream #(.DIN_W(8), .N_SAMPLES(8)) u_dut (
    .clk(clk), .rst(rst),
    .din_busy(din_busy), .din_vld(din_vld), .din_data(din_data),
    .dout_busy(dout_busy), .dout_vld(dout_vld), .dout_data(dout_data)
`ifdef ACCUM_STREAM_AVG_EN
    , .avg_mode(avg_mode)
`endif
  );

  accum_stream #(.DIN_W(16), .N_SAMPLES(4)) u_dut_w (
    .clk(clk), .rst(rst),
    .din_busy(b_din_busy), .din_vld(b_din_vld), .din_data(b_din_data),
    .dout_busy(b_dout_busy), .dout_vld(b_dout_vld), .dout_data(b_dout_data)
`ifdef ACCUM_STREAM_AVG_EN
    , .avg_mode(1'b0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one sample and advance past the edge where it is accepted.
  task automatic push(input logic [7:0] v);
    int n;
    din_data = v;
    din_vld  = 1'b1;
    n = 0;
    while (din_busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("push_timeout", 32'd1, 32'd0);
    tick();
  endtask

  task automatic push_w(input logic [15:0] v);
    int n;
    b_din_data = v;
    b_din_vld  = 1'b1;
    n = 0;
    while (b_din_busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("push_w_timeout", 32'd1, 32'd0);
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    din_vld = 1'b0; din_data = '0; dout_busy = 1'b0;
    b_din_vld = 1'b0; b_din_data = '0; b_dout_busy = 1'b0;
`ifdef ACCUM_STREAM_AVG_EN
    avg_mode = 1'b0;
`endif
    repeat (3) tick();
    check("rst_din_busy", 32'(din_busy), 32'd1);
    check("rst_dout_vld", 32'(dout_vld), 32'd0);
    check("rst_dout_data", 32'(dout_data), 32'd0);
    rst = 1'b1;
    tick();
    check("post_rst_din_busy", 32'(din_busy), 32'd0);

    // 8 x 0xFF back to back
    for (int i = 0; i < 7; i++) push(8'hFF);
    check("ff_vld_before_last", 32'(dout_vld), 32'd0);
    push(8'hFF);
    din_vld = 1'b0;
    check("ff_vld", 32'(dout_vld), 32'd1);
    check("ff_data", 32'(dout_data), 32'h7F8);
    check("ff_din_busy", 32'(din_busy), 32'd1);
    tick();
    check("ff_vld_drop", 32'(dout_vld), 32'd0);
    check("ff_busy_one_cycle", 32'(din_busy), 32'd0);

    // 1..8 with idle gaps between beats
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      if (i < 8) begin
        din_vld = 1'b0;
        repeat ((i % 3) + 1) tick();
        check("gap_no_vld", 32'(dout_vld), 32'd0);
      end
    end
    din_vld = 1'b0;
    check("gap_vld", 32'(dout_vld), 32'd1);
    check("gap_sum36", 32'(dout_data), 32'd36);
    tick();

    // output backpressure with a pending input sample held
    dout_busy = 1'b1;
    for (int i = 0; i < 8; i++) push(8'd3);
    din_data = 8'd100;
    din_vld  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", 32'(dout_vld), 32'd1);
      check("bp_data", 32'(dout_data), 32'd24);
      check("bp_din_busy", 32'(din_busy), 32'd1);
      tick();
    end
    dout_busy = 1'b0;
    tick();
    check("bp_release_vld", 32'(dout_vld), 32'd0);
    push(8'd100);
    for (int i = 0; i < 7; i++) push(8'd1);
    din_vld = 1'b0;
    check("bp_next_vld", 32'(dout_vld), 32'd1);
    check("bp_next_sum", 32'(dout_data), 32'd107);
    tick();

    // reset in the middle of a block
    for (int i = 0; i < 3; i++) push(8'd5);
    din_vld = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_din_busy", 32'(din_busy), 32'd1);
    check("midrst_dout_vld", 32'(dout_vld), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_release", 32'(din_busy), 32'd0);
    for (int i = 0; i < 8; i++) push(8'd2);
    din_vld = 1'b0;
    check("midrst_vld", 32'(dout_vld), 32'd1);
    check("midrst_sum16", 32'(dout_data), 32'd16);
    tick();

    // wide instance: 4 x 0xFFFF
    for (int i = 0; i < 3; i++) push_w(16'hFFFF);
    check("w_vld_before_last", 32'(b_dout_vld), 32'd0);
    push_w(16'hFFFF);
    b_din_vld = 1'b0;
    check("w_vld", 32'(b_dout_vld), 32'd1);
    check("w_data", 32'(b_dout_data), 32'h3FFFC);
    tick();
    check("w_vld_drop", 32'(b_dout_vld), 32'd0);

`ifdef ACCUM_STREAM_AVG_EN
    avg_mode = 1'b1;
    push(8'd1);
    avg_mode = 1'b0;
    for (int i = 2; i <= 8; i++) push(8'(i));
    din_vld = 1'b0;
    check("avg_vld", 32'(dout_vld), 32'd1);
    check("avg_data", 32'(dout_data), 32'd4);
    tick();
    for (int i = 1; i <= 8; i++) push(8'(i));
    din_vld = 1'b0;
    check("avg_off_data", 32'(dout_data), 32'd36);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
